// File: rtl/grf_pkg.sv
// grf_pkg: shared constants and helpers for the multi-port general register file.
`default_nettype none

package grf_pkg;

  localparam int ZERO_REG = 0;

  // Trace channel indices, one channel per write port
  localparam int TR_WB  = 0;
  localparam int TR_MDU = 1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/grf_rd_port.sv
// grf_rd_port: one combinational read port with zero check, write bypass and busy mask.
`default_nettype none

module grf_rd_port
  import grf_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int AW     = 5,
  parameter int BYPASS = 1
) (
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] reg_data_i,
  input  logic            busy_i,
  input  logic            wv0_i,
  input  logic [AW-1:0]   wa0_i,
  input  logic [XLEN-1:0] wd0_i,
  input  logic            wv1_i,
  input  logic [AW-1:0]   wa1_i,
  input  logic [XLEN-1:0] wd1_i,
  output logic [XLEN-1:0] data_o,
  output logic            busy_o
);

  logic hit0;
  logic hit1;
  logic is_zero;

  always_comb begin
    hit0    = wv0_i && (wa0_i == addr_i);
    hit1    = wv1_i && (wa1_i == addr_i);
    is_zero = (addr_i == AW'(ZERO_REG));
    data_o  = reg_data_i;
    if (is_zero) begin
      data_o = '0;
    end else if ((BYPASS != 0) && hit0) begin
      data_o = wd0_i;
    end else if ((BYPASS != 0) && hit1) begin
      data_o = wd1_i;
    end
    // A producer writing this cycle has already delivered its value through the bypass
    busy_o = busy_i && !is_zero && !((hit0 || hit1) && (BYPASS != 0));
  end

endmodule

`default_nettype wire

// File: rtl/grf_mp.sv
// grf_mp: NRD-read / 2-write register file with bypass, busy scoreboard and write trace.
`default_nettype none

module grf_mp
  import grf_pkg::*;
#(
  parameter  int XLEN   = 32,
  parameter  int NREG   = 32,
  parameter  int NRD    = 2,
  parameter  int BYPASS = 1,
  localparam int AW     = clog2(NREG)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NRD*AW-1:0]   rd_addr_i,
  output logic [NRD*XLEN-1:0] rd_data_o,
  output logic [NRD-1:0]      rd_busy_o,
  input  logic                we0_i,
  input  logic [AW-1:0]       wa0_i,
  input  logic [XLEN-1:0]     wd0_i,
  input  logic [31:0]         pc0_i,
  input  logic                we1_i,
  input  logic [AW-1:0]       wa1_i,
  input  logic [XLEN-1:0]     wd1_i,
  input  logic [31:0]         pc1_i,
  input  logic                iss_valid_i,
  input  logic [AW-1:0]       iss_addr_i,
  output logic                w1_drop_o,
  output logic [1:0]          tr_valid_o,
  output logic [63:0]         tr_pc_o,
  output logic [2*AW-1:0]     tr_addr_o,
  output logic [2*XLEN-1:0]   tr_data_o
);

  logic [XLEN-1:0]   regs_q [NREG];
  logic [NREG-1:0]   busy_q;
  logic [NREG-1:0]   busy_d;
  logic              w1_drop_q;
  logic [1:0]        tr_valid_q;
  logic [63:0]       tr_pc_q;
  logic [2*AW-1:0]   tr_addr_q;
  logic [2*XLEN-1:0] tr_data_q;

  logic wv0;
  logic wv1_raw;
  logic w1_conflict;
  logic wv1;

  always_comb begin
    wv0         = we0_i && (wa0_i != AW'(ZERO_REG));
    wv1_raw     = we1_i && (wa1_i != AW'(ZERO_REG));
    w1_conflict = wv0 && wv1_raw && (wa0_i == wa1_i);
    wv1         = wv1_raw && !w1_conflict;
  end

  // Clears first so a same-cycle issue (new producer) overrides the retiring write
  always_comb begin
    busy_d = busy_q;
    if (wv0) busy_d[wa0_i] = 1'b0;
    if (wv1) busy_d[wa1_i] = 1'b0;
    if (iss_valid_i) busy_d[iss_addr_i] = 1'b1;
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      busy_q     <= '0;
      w1_drop_q  <= 1'b0;
      tr_valid_q <= '0;
      tr_pc_q    <= '0;
      tr_addr_q  <= '0;
      tr_data_q  <= '0;
    end else begin
      if (wv0) regs_q[wa0_i] <= wd0_i;
      if (wv1) regs_q[wa1_i] <= wd1_i;
      busy_q     <= busy_d;
      w1_drop_q  <= w1_conflict;
      tr_valid_q <= {wv1, wv0};
      if (wv0) begin
        tr_pc_q[TR_WB*32 +: 32]     <= pc0_i;
        tr_addr_q[TR_WB*AW +: AW]   <= wa0_i;
        tr_data_q[TR_WB*XLEN +: XLEN] <= wd0_i;
      end
      if (wv1) begin
        tr_pc_q[TR_MDU*32 +: 32]     <= pc1_i;
        tr_addr_q[TR_MDU*AW +: AW]   <= wa1_i;
        tr_data_q[TR_MDU*XLEN +: XLEN] <= wd1_i;
      end
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    grf_rd_port #(
      .XLEN   (XLEN),
      .AW     (AW),
      .BYPASS (BYPASS)
    ) u_rd_port (
      .addr_i     (rd_addr_i[k*AW +: AW]),
      .reg_data_i (regs_q[rd_addr_i[k*AW +: AW]]),
      .busy_i     (busy_q[rd_addr_i[k*AW +: AW]]),
      .wv0_i      (wv0),
      .wa0_i      (wa0_i),
      .wd0_i      (wd0_i),
      .wv1_i      (wv1),
      .wa1_i      (wa1_i),
      .wd1_i      (wd1_i),
      .data_o     (rd_data_o[k*XLEN +: XLEN]),
      .busy_o     (rd_busy_o[k])
    );
  end

  assign w1_drop_o  = w1_drop_q;
  assign tr_valid_o = tr_valid_q;
  assign tr_pc_o    = tr_pc_q;
  assign tr_addr_o  = tr_addr_q;
  assign tr_data_o  = tr_data_q;

endmodule

`default_nettype wire

// File: tb/tb_grf_mp.sv
// tb_grf_mp: directed self-checking bench for grf_mp with default parameters.
`default_nettype none

module tb_grf_mp;

  logic        clk;
  logic        reset;
  logic [9:0]  rd_addr;
  logic [63:0] rd_data;
  logic [1:0]  rd_busy;
  logic        we0, we1;
  logic [4:0]  wa0, wa1;
  logic [31:0] wd0, wd1, pc0, pc1;
  logic        iss_valid;
  logic [4:0]  iss_addr;
  logic        w1_drop;
  logic [1:0]  tr_valid;
  logic [63:0] tr_pc;
  logic [9:0]  tr_addr;
  logic [63:0] tr_data;

  int checks = 0;
  int errors = 0;

  grf_mp dut (
    .clk         (clk),
    .reset       (reset),
    .rd_addr_i   (rd_addr),
    .rd_data_o   (rd_data),
    .rd_busy_o   (rd_busy),
    .we0_i       (we0),
    .wa0_i       (wa0),
    .wd0_i       (wd0),
    .pc0_i       (pc0),
    .we1_i       (we1),
    .wa1_i       (wa1),
    .wd1_i       (wd1),
    .pc1_i       (pc1),
    .iss_valid_i (iss_valid),
    .iss_addr_i  (iss_addr),
    .w1_drop_o   (w1_drop),
    .tr_valid_o  (tr_valid),
    .tr_pc_o     (tr_pc),
    .tr_addr_o   (tr_addr),
    .tr_data_o   (tr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; outputs settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we0 = 0; we1 = 0; iss_valid = 0;
  endtask

  initial begin
    reset = 1; rd_addr = '0; we0 = 0; we1 = 0; wa0 = 0; wa1 = 0;
    wd0 = 0; wd1 = 0; pc0 = 0; pc1 = 0; iss_valid = 0; iss_addr = 0;
    tick(); tick();
    reset = 0;
    #1;
    check("rst_tr_valid", {62'd0, tr_valid}, 64'd0);
    check("rst_w1_drop", {63'd0, w1_drop}, 64'd0);
    check("rst_tr_pc", tr_pc, 64'd0);
    for (int a = 0; a < 32; a++) begin
      rd_addr = {5'(31 - a), 5'(a)};
      #1;
      check("rst_rd_data", rd_data, 64'd0);
      check("rst_rd_busy", {62'd0, rd_busy}, 64'd0);
    end

    // Port-0 write with same-cycle bypass
    we0 = 1; wa0 = 5; wd0 = 32'hDEADBEEF; pc0 = 32'h3000; rd_addr = {5'd0, 5'd5};
    #1;
    check("bypass_wb", {32'd0, rd_data[31:0]}, 64'hDEADBEEF);
    tick(); idle(); rd_addr = {5'd5, 5'd0};
    #1;
    check("tr_valid_wb", {62'd0, tr_valid}, 64'd1);
    check("tr_pc_wb", {32'd0, tr_pc[31:0]}, 64'h3000);
    check("tr_addr_wb", {59'd0, tr_addr[4:0]}, 64'd5);
    check("tr_data_wb", {32'd0, tr_data[31:0]}, 64'hDEADBEEF);
    check("read5_port1", rd_data, {32'hDEADBEEF, 32'd0});
    tick();
    check("tr_pulse_one_cycle", {62'd0, tr_valid}, 64'd0);

    // Writes to $0 are ignored
    we0 = 1; we1 = 1; wa0 = 0; wa1 = 0; wd0 = 32'h12345678; wd1 = 32'h12345678;
    rd_addr = {5'd0, 5'd0};
    #1;
    check("zero_bypass", rd_data, 64'd0);
    tick(); idle();
    #1;
    check("zero_read", rd_data, 64'd0);
    check("zero_no_trace", {62'd0, tr_valid}, 64'd0);
    check("zero_no_drop", {63'd0, w1_drop}, 64'd0);

    // Conflict: port 0 wins, port 1 dropped
    we0 = 1; we1 = 1; wa0 = 8; wa1 = 8; wd0 = 32'h1; wd1 = 32'h2;
    pc0 = 32'h100; pc1 = 32'h200; rd_addr = {5'd8, 5'd8};
    #1;
    check("conflict_bypass", rd_data, {32'h1, 32'h1});
    tick(); idle();
    #1;
    check("conflict_drop", {63'd0, w1_drop}, 64'd1);
    check("conflict_trace", {62'd0, tr_valid}, 64'd1);
    check("conflict_tr_pc", {32'd0, tr_pc[31:0]}, 64'h100);
    check("conflict_read", rd_data, {32'h1, 32'h1});
    tick();
    check("drop_pulse", {63'd0, w1_drop}, 64'd0);

    // Dual commit to different addresses
    we0 = 1; we1 = 1; wa0 = 10; wa1 = 11; wd0 = 32'hAA; wd1 = 32'hBB;
    pc0 = 32'h300; pc1 = 32'h400;
    tick(); idle(); rd_addr = {5'd11, 5'd10};
    #1;
    check("dual_trace", {62'd0, tr_valid}, 64'd3);
    check("dual_tr_pc", tr_pc, {32'h400, 32'h300});
    check("dual_tr_addr", {54'd0, tr_addr}, {54'd0, 5'd11, 5'd10});
    check("dual_tr_data", tr_data, {32'hBB, 32'hAA});
    check("dual_read", rd_data, {32'hBB, 32'hAA});

    // Scoreboard: issue, then retire via port 1
    iss_valid = 1; iss_addr = 9; rd_addr = {5'd0, 5'd9};
    #1;
    check("busy_not_yet", {62'd0, rd_busy}, 64'd0);
    tick(); idle();
    #1;
    check("busy_set", {62'd0, rd_busy}, 64'd1);
    we1 = 1; wa1 = 9; wd1 = 32'h77; pc1 = 32'h500;
    #1;
    check("busy_masked", {62'd0, rd_busy}, 64'd0);
    check("bypass_mdu", {32'd0, rd_data[31:0]}, 64'h77);
    tick(); idle();
    #1;
    check("busy_cleared", {62'd0, rd_busy}, 64'd0);
    check("read9", {32'd0, rd_data[31:0]}, 64'h77);
    check("tr_mdu", {62'd0, tr_valid}, 64'd2);
    check("tr_mdu_addr", {59'd0, tr_addr[9:5]}, 64'd9);

    // Issue and write same address: set wins
    iss_valid = 1; iss_addr = 9; we0 = 1; wa0 = 9; wd0 = 32'h99;
    tick(); idle();
    #1;
    check("set_wins", {62'd0, rd_busy}, 64'd1);
    iss_valid = 1; iss_addr = 0; rd_addr = {5'd0, 5'd0};
    tick(); idle();
    #1;
    check("busy_zero", {62'd0, rd_busy}, 64'd0);

    // Reset overrides pending busy, writes and issues
    iss_valid = 1; iss_addr = 3;
    tick();
    iss_addr = 4;
    tick(); idle();
    rd_addr = {5'd4, 5'd3};
    #1;
    check("busy_3_4", {62'd0, rd_busy}, 64'd3);
    reset = 1; we0 = 1; wa0 = 3; wd0 = 32'h55; iss_valid = 1; iss_addr = 5;
    #1;
    check("reset_cycle_bypass", {32'd0, rd_data[31:0]}, 64'h55);
    tick(); reset = 0; idle();
    #1;
    check("reset_busy", {62'd0, rd_busy}, 64'd0);
    check("reset_reg3", rd_data, 64'd0);
    rd_addr = {5'd9, 5'd5};
    #1;
    check("reset_busy_5_9", {62'd0, rd_busy}, 64'd0);
    check("reset_reg9", rd_data, 64'd0);
    check("reset_trace", {62'd0, tr_valid}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
